// File: rtl/dest_ip_tbl_pkg.sv
// Shared types and helpers for the destination-IP table arbiter.
package dest_ip_tbl_pkg;

  localparam int TBL_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_SW  = 1'b0,
    SRC_LKP = 1'b1
  } src_t;

  // Bits needed to hold values 0..max_val (timeout and starvation counters).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dest_ip_tbl_arbiter.sv
// Serialises software and lookup accesses onto the single-ported dest_ip table,
// lookup-first with a starvation guard, and a timeout for missing table acks.
module dest_ip_tbl_arbiter
  import dest_ip_tbl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MAX_STARVE         = 4,
  parameter int ACK_TIMEOUT        = 16
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESETN,
  input  logic                          sw_req,
  input  logic                          sw_wr,
  input  logic [TBL_ADDR_WIDTH-1:0]     sw_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] sw_wdata,
  output logic                          sw_ack,
  output logic [C_S_AXI_DATA_WIDTH-1:0] sw_rdata,
  output logic                          sw_err,
  input  logic                          lkp_req,
  input  logic [TBL_ADDR_WIDTH-1:0]     lkp_addr,
  output logic                          lkp_ack,
  output logic [C_S_AXI_DATA_WIDTH-1:0] lkp_rdata,
  output logic                          lkp_err,
  output logic                          tbl_rd_req,
  output logic                          tbl_wr_req,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                          tbl_rd_ack,
  input  logic                          tbl_wr_ack,
  output logic                          busy,
  output logic [31:0]                   timeout_cnt
);

  localparam int TO_W = cnt_width(ACK_TIMEOUT);
  localparam int SV_W = cnt_width(MAX_STARVE);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [SV_W-1:0] SV_MAX  = SV_W'(MAX_STARVE);
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] DATA_ZERO = {C_S_AXI_DATA_WIDTH{1'b0}};

  state_t                          state_r;
  src_t                            src_r;
  logic                            wr_r;
  logic [TO_W-1:0]                 wait_cnt_r;
  logic [SV_W-1:0]                 starve_cnt_r;
  logic                            sw_ack_r, sw_err_r, lkp_ack_r, lkp_err_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]   sw_rdata_r, lkp_rdata_r, tbl_wr_data_r;
  logic                            tbl_rd_req_r, tbl_wr_req_r, busy_r;
  logic [TBL_ADDR_WIDTH-1:0]       tbl_rd_addr_r, tbl_wr_addr_r;
  logic [31:0]                     timeout_cnt_r;
  logic                            lkp_win_s;
  logic                            ack_hit_s;

  // Grant decision and ack qualification for the access in flight.
  always_comb begin
    lkp_win_s = 1'b0;
    ack_hit_s = 1'b0;
    if (lkp_req && !(sw_req && (starve_cnt_r == SV_MAX))) begin
      lkp_win_s = 1'b1;
    end else begin
      lkp_win_s = 1'b0;
    end
    if (wr_r) begin
      ack_hit_s = tbl_wr_ack;
    end else begin
      ack_hit_s = tbl_rd_ack;
    end
  end

  // Access FSM with all outputs registered.
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      state_r       <= IDLE;
      src_r         <= SRC_SW;
      wr_r          <= 1'b0;
      wait_cnt_r    <= {TO_W{1'b0}};
      starve_cnt_r  <= {SV_W{1'b0}};
      sw_ack_r      <= 1'b0;
      sw_err_r      <= 1'b0;
      sw_rdata_r    <= DATA_ZERO;
      lkp_ack_r     <= 1'b0;
      lkp_err_r     <= 1'b0;
      lkp_rdata_r   <= DATA_ZERO;
      tbl_rd_req_r  <= 1'b0;
      tbl_wr_req_r  <= 1'b0;
      tbl_rd_addr_r <= {TBL_ADDR_WIDTH{1'b0}};
      tbl_wr_addr_r <= {TBL_ADDR_WIDTH{1'b0}};
      tbl_wr_data_r <= DATA_ZERO;
      busy_r        <= 1'b0;
      timeout_cnt_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sw_req || lkp_req) begin
            state_r <= ISSUE;
            busy_r  <= 1'b1;
            if (lkp_win_s) begin
              src_r         <= SRC_LKP;
              wr_r          <= 1'b0;
              tbl_rd_req_r  <= 1'b1;
              tbl_rd_addr_r <= lkp_addr;
              starve_cnt_r  <= sw_req ? (starve_cnt_r + 1'b1) : {SV_W{1'b0}};
            end else begin
              src_r        <= SRC_SW;
              wr_r         <= sw_wr;
              tbl_rd_req_r <= ~sw_wr;
              tbl_wr_req_r <= sw_wr;
              starve_cnt_r <= {SV_W{1'b0}};
              if (sw_wr) begin
                tbl_wr_addr_r <= sw_addr;
                tbl_wr_data_r <= sw_wdata;
              end else begin
                tbl_rd_addr_r <= sw_addr;
              end
            end
          end else begin
            starve_cnt_r <= {SV_W{1'b0}};
          end
        end
        ISSUE: begin
          tbl_rd_req_r <= 1'b0;
          tbl_wr_req_r <= 1'b0;
          wait_cnt_r   <= {TO_W{1'b0}};
          state_r      <= WAIT;
        end
        WAIT: begin
          // A real ack in the final counted cycle still completes without error.
          if (ack_hit_s || (wait_cnt_r == TO_LAST)) begin
            state_r <= RESP;
            if (src_r == SRC_LKP) begin
              lkp_ack_r   <= 1'b1;
              lkp_err_r   <= ~ack_hit_s;
              lkp_rdata_r <= ack_hit_s ? tbl_rd_data : DATA_ZERO;
            end else begin
              sw_ack_r   <= 1'b1;
              sw_err_r   <= ~ack_hit_s;
              sw_rdata_r <= (ack_hit_s && !wr_r) ? tbl_rd_data : DATA_ZERO;
            end
            if (!ack_hit_s) begin
              timeout_cnt_r <= timeout_cnt_r + 32'd1;
            end else begin
              timeout_cnt_r <= timeout_cnt_r;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
        end
        RESP: begin
          sw_ack_r    <= 1'b0;
          sw_err_r    <= 1'b0;
          sw_rdata_r  <= DATA_ZERO;
          lkp_ack_r   <= 1'b0;
          lkp_err_r   <= 1'b0;
          lkp_rdata_r <= DATA_ZERO;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          busy_r       <= 1'b0;
          tbl_rd_req_r <= 1'b0;
          tbl_wr_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign sw_ack      = sw_ack_r;
  assign sw_rdata    = sw_rdata_r;
  assign sw_err      = sw_err_r;
  assign lkp_ack     = lkp_ack_r;
  assign lkp_rdata   = lkp_rdata_r;
  assign lkp_err     = lkp_err_r;
  assign tbl_rd_req  = tbl_rd_req_r;
  assign tbl_wr_req  = tbl_wr_req_r;
  assign tbl_rd_addr = tbl_rd_addr_r;
  assign tbl_wr_addr = tbl_wr_addr_r;
  assign tbl_wr_data = tbl_wr_data_r;
  assign busy        = busy_r;
  assign timeout_cnt = timeout_cnt_r;

endmodule

// File: tb/tb_dest_ip_tbl_arbiter.sv
// Self-checking bench: table responder model, vector table, random accesses
// against a shadow memory, plus hand sequences for arbitration, timeout and reset.
module tb_dest_ip_tbl_arbiter;

  logic        clk = 1'b0;
  logic        AXI_RESETN = 1'b0;
  logic        sw_req = 1'b0, sw_wr = 1'b0;
  logic [4:0]  sw_addr = 5'd0;
  logic [31:0] sw_wdata = 32'd0;
  logic        sw_ack, sw_err, lkp_ack, lkp_err;
  logic [31:0] sw_rdata, lkp_rdata;
  logic        lkp_req = 1'b0;
  logic [4:0]  lkp_addr = 5'd0;
  logic        tbl_rd_req, tbl_wr_req, busy;
  logic [4:0]  tbl_rd_addr, tbl_wr_addr;
  logic [31:0] tbl_wr_data, timeout_cnt;
  logic [31:0] tbl_rd_data = 32'd0;
  logic        tbl_rd_ack = 1'b0, tbl_wr_ack = 1'b0;

  dest_ip_tbl_arbiter dut (
    .AXI_ACLK(clk), .AXI_RESETN(AXI_RESETN),
    .sw_req(sw_req), .sw_wr(sw_wr), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
    .sw_ack(sw_ack), .sw_rdata(sw_rdata), .sw_err(sw_err),
    .lkp_req(lkp_req), .lkp_addr(lkp_addr), .lkp_ack(lkp_ack),
    .lkp_rdata(lkp_rdata), .lkp_err(lkp_err),
    .tbl_rd_req(tbl_rd_req), .tbl_wr_req(tbl_wr_req),
    .tbl_rd_addr(tbl_rd_addr), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .tbl_rd_data(tbl_rd_data), .tbl_rd_ack(tbl_rd_ack), .tbl_wr_ack(tbl_wr_ack),
    .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  // Knobs owned by the main sequence, read by the table model.
  bit suppress = 1'b0, inj_rd = 1'b0, inj_wr = 1'b0;
  int extra_delay = 0;
  bit both_seen = 1'b0;

  function automatic logic [31:0] pat(input int i);
    return 32'hA5000000 ^ (i * 32'h00010203);
  endfunction

  // Table model: acks one cycle after the strobe (plus extra_delay).
  logic [31:0] mem [32];
  bit mem_loaded = 1'b0;
  int rd_cnt = 0, wr_cnt = 0;
  logic [4:0] rd_addr_q = 5'd0;
  always @(posedge clk) begin
    #1;
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] = pat(i);
      mem_loaded = 1'b1;
    end
    tbl_rd_ack = 1'b0; tbl_wr_ack = 1'b0; tbl_rd_data = 32'd0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0 && !suppress) begin tbl_rd_ack = 1'b1; tbl_rd_data = mem[rd_addr_q]; end
    end
    if (wr_cnt > 0) begin
      wr_cnt--;
      if (wr_cnt == 0 && !suppress) tbl_wr_ack = 1'b1;
    end
    if (tbl_rd_req) begin rd_cnt = 1 + extra_delay; rd_addr_q = tbl_rd_addr; end
    if (tbl_wr_req) begin mem[tbl_wr_addr] = tbl_wr_data; wr_cnt = 1 + extra_delay; end
    if (inj_rd) begin tbl_rd_ack = 1'b1; tbl_rd_data = 32'hBAD0BAD0; end
    if (inj_wr) tbl_wr_ack = 1'b1;
  end

  always @(negedge clk) if (tbl_rd_req && tbl_wr_req) both_seen = 1'b1;

  int n_vec = 0, n_err = 0;
  logic [31:0] exp_mem [32];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_access(input bit is_sw, input bit wr, input logic [4:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output int nrd, output int nwr);
    bit got = 1'b0;
    lat = 0; nrd = 0; nwr = 0; rdata = 32'hFFFFFFFF; err = 1'bx;
    if (is_sw) begin sw_req = 1'b1; sw_wr = wr; sw_addr = addr; sw_wdata = wdata; end
    else begin lkp_req = 1'b1; lkp_addr = addr; end
    while (!got && lat < 100) begin
      tick(); lat++;
      nrd += int'(tbl_rd_req); nwr += int'(tbl_wr_req);
      if (is_sw ? sw_ack : lkp_ack) begin
        got = 1'b1;
        rdata = is_sw ? sw_rdata : lkp_rdata;
        err = is_sw ? sw_err : lkp_err;
      end
    end
    sw_req = 1'b0; lkp_req = 1'b0;
    if (!got) chk("ack_bound", 32'd0, 32'd1);
    tick();
  endtask

  typedef struct {
    bit          is_sw;
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vecs[9];
    logic [31:0] rd;
    logic er;
    int lat, nrd, nwr, lc, swacks, na, cyc, idle, bad;
    bit started;

    for (int i = 0; i < 32; i++) exp_mem[i] = pat(i);
    vecs[0] = '{1'b1, 1'b1, 5'd3,  32'hC0A80001, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 5'd3,  32'h0,        32'hC0A80001};
    vecs[2] = '{1'b0, 1'b0, 5'd3,  32'h0,        32'hC0A80001};
    vecs[3] = '{1'b1, 1'b1, 5'd31, 32'hDEADBEEF, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 5'd31, 32'h0,        32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 5'd0,  32'h0,        pat(0)};
    vecs[6] = '{1'b0, 1'b0, 5'd17, 32'h0,        pat(17)};
    vecs[7] = '{1'b1, 1'b1, 5'd3,  32'h0,        32'h0};
    vecs[8] = '{1'b0, 1'b0, 5'd3,  32'h0,        32'h0};

    // Reset state
    tick(); tick();
    chk("rst_outputs", {31'd0, |{sw_ack, sw_rdata, sw_err, lkp_ack, lkp_rdata, lkp_err,
        tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data, busy, timeout_cnt}}, 32'd0);
    AXI_RESETN = 1'b1;
    tick();

    // Vector table
    for (int v = 0; v < 9; v++) begin
      do_access(vecs[v].is_sw, vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd, er, lat, nrd, nwr);
      if (vecs[v].wr) exp_mem[vecs[v].addr] = vecs[v].wdata;
      chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_err", v), {31'd0, er}, 32'd0);
      chk($sformatf("vec%0d_latency", v), lat, 32'd3);
      chk($sformatf("vec%0d_wr_strobes", v), nwr, {31'd0, vecs[v].wr});
      chk($sformatf("vec%0d_rd_strobes", v), nrd, {31'd0, ~vecs[v].wr});
    end

    // Random single-requester traffic against the shadow memory
    for (int k = 0; k < 120; k++) begin
      bit s, w;
      logic [4:0] a;
      logic [31:0] d, e;
      s = 1'($urandom_range(0, 1));
      w = s & 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      e = w ? 32'd0 : exp_mem[a];
      do_access(s, w, a, d, rd, er, lat, nrd, nwr);
      if (w) exp_mem[a] = d;
      chk($sformatf("rnd%0d_rdata", k), rd, e);
      chk($sformatf("rnd%0d_err_lat", k), {30'd0, er, 1'b0} + lat, 32'd3);
    end

    // Both requesters held: every software grant follows exactly 4 lookup grants
    sw_req = 1'b1; sw_wr = 1'b0; sw_addr = 5'd7;
    lkp_req = 1'b1; lkp_addr = 5'd0;
    lc = 0; swacks = 0;
    for (int c = 0; c < 200 && swacks < 2; c++) begin
      tick();
      if (sw_ack && lkp_ack) chk("arb_dual_ack", 32'd1, 32'd0);
      if (lkp_ack) begin
        chk("arb_lkp_rdata", lkp_rdata, exp_mem[lkp_addr]);
        lc++; lkp_addr = lkp_addr + 5'd1;
      end
      if (sw_ack) begin
        chk("arb_lkp_before_sw", lc, 32'd4);
        chk("arb_sw_rdata", sw_rdata, exp_mem[7]);
        lc = 0; swacks++;
      end
    end
    sw_req = 1'b0; lkp_req = 1'b0;
    chk("arb_sw_grants", swacks, 32'd2);
    tick(); tick();

    // Missing table ack -> timeout error, then normal recovery
    chk("to_cnt_before", timeout_cnt, 32'd0);
    suppress = 1'b1;
    do_access(1'b0, 1'b0, 5'd5, 32'd0, rd, er, lat, nrd, nwr);
    suppress = 1'b0;
    chk("to_err", {31'd0, er}, 32'd1);
    chk("to_rdata", rd, 32'd0);
    chk("to_latency", lat, 32'd18);
    chk("to_cnt_after", timeout_cnt, 32'd1);
    do_access(1'b0, 1'b0, 5'd5, 32'd0, rd, er, lat, nrd, nwr);
    chk("to_recover_rdata", rd, exp_mem[5]);
    chk("to_recover_err_lat", {30'd0, er, 1'b0} + lat, 32'd3);

    // Stray acks: rd_ack while idle, wr_ack throughout a delayed read
    inj_rd = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      bad += int'(sw_ack | lkp_ack | busy);
    end
    inj_rd = 1'b0;
    tick();
    chk("stray_idle", bad, 32'd0);
    extra_delay = 3; inj_wr = 1'b1;
    do_access(1'b1, 1'b0, 5'd9, 32'd0, rd, er, lat, nrd, nwr);
    extra_delay = 0; inj_wr = 1'b0;
    chk("stray_wr_rdata", rd, exp_mem[9]);
    chk("stray_wr_latency", lat, 32'd6);
    chk("stray_wr_err", {31'd0, er}, 32'd0);
    chk("stray_to_cnt", timeout_cnt, 32'd1);

    // Back-to-back lookups over the whole table
    lkp_req = 1'b1; lkp_addr = 5'd0;
    na = 0; cyc = 0; idle = 0; started = 1'b0;
    for (int c = 0; c < 400 && na < 32; c++) begin
      tick();
      if (started) begin cyc++; idle += int'(!busy); end
      if (lkp_ack) begin
        chk($sformatf("b2b_rdata%0d", lkp_addr), lkp_rdata, exp_mem[lkp_addr]);
        na++; started = 1'b1; lkp_addr = lkp_addr + 5'd1;
        if (na == 32) lkp_req = 1'b0;
      end
    end
    lkp_req = 1'b0;
    chk("b2b_acks", na, 32'd32);
    chk("b2b_cycles", cyc, 32'd124);
    chk("b2b_idle", idle, 32'd31);
    tick(); tick();

    // Reset during WAIT with a late table ack arriving afterwards
    extra_delay = 5;
    sw_req = 1'b1; sw_wr = 1'b0; sw_addr = 5'd12;
    tick(); tick();
    chk("rst_mid_busy", {31'd0, busy}, 32'd1);
    AXI_RESETN = 1'b0; sw_req = 1'b0;
    tick();
    AXI_RESETN = 1'b1;
    chk("rst_mid_outputs", {31'd0, |{sw_ack, sw_rdata, sw_err, lkp_ack, lkp_rdata, lkp_err,
        tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data, busy, timeout_cnt}}, 32'd0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      bad += int'(sw_ack | lkp_ack | busy);
    end
    chk("rst_late_ack_ignored", bad, 32'd0);
    extra_delay = 0;
    do_access(1'b1, 1'b0, 5'd12, 32'd0, rd, er, lat, nrd, nwr);
    chk("rst_reissue_rdata", rd, exp_mem[12]);
    chk("rst_reissue_err_lat", {30'd0, er, 1'b0} + lat, 32'd3);

    chk("strobes_exclusive", {31'd0, both_seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
